car_lane_controller: RTL and testbench

Upstream neighbour of the sprite display stage. It generates the four car X positions and per-lane reverse flags that the display consumes.
Positions advance once per frame, in vertical blanking, so the display never sees a position change mid-frame. Each lane has its own speed divider, scaled by the game level, plus pause and restart control.

---
 rtl/car_lane_pkg.sv | 39 +++
 rtl/car_lane.sv | 99 +++++++++
 rtl/car_lane_controller.sv | 86 ++++++++
 tb/tb_car_lane_controller.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/car_lane_pkg.sv
// Shared constants, types and helpers for the car lane controller.
//
// Contents:
//   - Display geometry (visible area, sprite width, largest legal car X)
//   - Lane count and the field widths used in the packed per-lane parameters
//   - eff_period(): a lane's base period scaled down by the game level
package car_lane_pkg;

    // Display geometry
    localparam int unsigned H_VISIBLE_AREA = 640;
    localparam int unsigned V_VISIBLE_AREA = 480;
    localparam int unsigned TILE_SIZE      = 32;
    localparam int unsigned X_MAX          = H_VISIBLE_AREA - TILE_SIZE;

    // Lane organisation and packed-parameter field widths
    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned PERIOD_W  = 8;
    localparam int unsigned STEP_W    = 4;
    localparam int unsigned X_W       = 10;
    localparam int unsigned CTR_W     = 10;
    localparam int unsigned LEVEL_W   = 2;

    typedef logic [X_W-1:0]      x_pos_t;
    typedef logic [PERIOD_W-1:0] period_t;
    typedef logic [STEP_W-1:0]   step_t;
    typedef logic [LEVEL_W-1:0]  level_t;

    // Each level halves the frames-per-step; a period of zero would stall
    // the lane, so the result is clamped to one frame per step.
    function automatic period_t eff_period(input period_t period, input level_t level);
        period_t p;
        p = period >> level;
        if (p == '0) begin
            p = period_t'(1);
        end
        return p;
    endfunction

endpackage

// File: rtl/car_lane.sv
// One traffic lane: frame divider, X position register and edge wrap.
//
// Ports:
//   clk      in   pixel clock
//   rst_n    in   asynchronous active-low reset
//   tick     in   one-cycle frame update strobe (vertical blanking)
//   pause    in   1 = hold position and divider at a tick
//   restart  in   1 = reload INIT_X and clear divider on the next edge
//   level    in   speed level, shifts the base period right
//   x        out  current car X, always within [0, X_MAX]
//
// Parameters:
//   REVERSE  0 = moves left-to-right, 1 = moves right-to-left
//   PERIOD   base frames per step
//   STEP     pixels moved per step
//   INIT_X   X after reset or restart
module car_lane
    import car_lane_pkg::*;
#(
    parameter bit      REVERSE = 1'b0,
    parameter period_t PERIOD  = period_t'(1),
    parameter step_t   STEP    = step_t'(1),
    parameter x_pos_t  INIT_X  = '0
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   tick,
    input  logic   pause,
    input  logic   restart,
    input  level_t level,
    output x_pos_t x
);

    // One extra bit so x + STEP cannot overflow before the range check
    localparam logic [X_W:0] X_MAX_EXT = (X_W + 1)'(X_MAX);
    localparam logic [X_W:0] STEP_EXT  = (X_W + 1)'(STEP);

    period_t          div_q, div_d;
    x_pos_t           x_q, x_d;
    period_t          p_eff;
    logic [PERIOD_W:0] div_inc;
    logic [X_W:0]     x_sum;
    x_pos_t           x_step;

    always_comb begin
        p_eff   = eff_period(PERIOD, level);
        div_inc = {1'b0, div_q} + (PERIOD_W + 1)'(1);
        x_sum   = {1'b0, x_q} + STEP_EXT;
        x_step  = x_q;

        if (REVERSE) begin
            // Leaving the left edge re-enters at the rightmost legal X
            if ({1'b0, x_q} < STEP_EXT) begin
                x_step = X_MAX_EXT[X_W-1:0];
            end else begin
                x_step = x_q - x_pos_t'(STEP);
            end
        end else begin
            // Passing the rightmost legal X re-enters at the left edge
            if (x_sum > X_MAX_EXT) begin
                x_step = '0;
            end else begin
                x_step = x_sum[X_W-1:0];
            end
        end
    end

    always_comb begin
        div_d = div_q;
        x_d   = x_q;
        if (restart) begin
            // Restart wins over a coincident tick and over pause
            div_d = '0;
            x_d   = INIT_X;
        end else if (tick && !pause) begin
            // >= rather than == so a level change that shortens the period
            // below the current count steps immediately instead of wrapping
            if (div_inc >= {1'b0, p_eff}) begin
                div_d = '0;
                x_d   = x_step;
            end else begin
                div_d = div_inc[PERIOD_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            x_q   <= INIT_X;
        end else begin
            div_q <= div_d;
            x_q   <= x_d;
        end
    end

    assign x = x_q;

endmodule

// File: rtl/car_lane_controller.sv
// Car lane controller: produces the four car X positions and reverse flags
// consumed by the sprite display stage. Positions change only on the single
// cycle following the start of vertical blanking, so the display never sees
// a position move mid-frame.
//
// Ports:
//   i_Clk              in   pixel clock
//   i_Rst_N            in   asynchronous active-low reset
//   i_H_Counter        in   current pixel column
//   i_V_Counter        in   current line
//   i_Pause            in   1 = freeze all lanes
//   i_Restart          in   one-cycle pulse, reload initial positions
//   i_Level            in   speed level 0..3
//   o_Car_1X_Position  out  lane 1 X
//   o_Car_2X_Position  out  lane 2 X
//   o_Car_3X_Position  out  lane 3 X
//   o_Car_4X_Position  out  lane 4 X
//   o_Reverse          out  per-lane direction flags (constant)
//   o_Frame_Tick       out  one-cycle pulse on the cycle positions update
//
// Packed per-lane parameters hold lane 1 in the least significant field.
module car_lane_controller
    import car_lane_pkg::*;
#(
    parameter logic [NUM_LANES-1:0]          LANE_REVERSE = 4'b1010,
    parameter logic [NUM_LANES*PERIOD_W-1:0] LANE_PERIOD  = {8'd4, 8'd3, 8'd2, 8'd1},
    parameter logic [NUM_LANES*STEP_W-1:0]   LANE_STEP    = {4'd4, 4'd2, 4'd3, 4'd2},
    parameter logic [NUM_LANES*X_W-1:0]      LANE_INIT_X  = {10'd480, 10'd320, 10'd160, 10'd0}
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst_N,
    input  logic [CTR_W-1:0]     i_H_Counter,
    input  logic [CTR_W-1:0]     i_V_Counter,
    input  logic                 i_Pause,
    input  logic                 i_Restart,
    input  logic [LEVEL_W-1:0]   i_Level,
    output logic [X_W-1:0]       o_Car_1X_Position,
    output logic [X_W-1:0]       o_Car_2X_Position,
    output logic [X_W-1:0]       o_Car_3X_Position,
    output logic [X_W-1:0]       o_Car_4X_Position,
    output logic [NUM_LANES-1:0] o_Reverse,
    output logic                 o_Frame_Tick
);

    logic   tick_cond;
    logic   frame_tick_q;
    x_pos_t lane_x [NUM_LANES];

    // First pixel of the first blanking line; exactly one cycle per frame
    assign tick_cond = (i_V_Counter == CTR_W'(V_VISIBLE_AREA)) && (i_H_Counter == '0);

    always_ff @(posedge i_Clk or negedge i_Rst_N) begin
        if (!i_Rst_N) begin
            frame_tick_q <= 1'b0;
        end else begin
            frame_tick_q <= tick_cond;
        end
    end

    // Lanes consume the unregistered condition so their registers update on
    // the same edge that raises o_Frame_Tick.
    for (genvar n = 0; n < NUM_LANES; n++) begin : gen_lane
        car_lane #(
            .REVERSE (LANE_REVERSE[n]),
            .PERIOD  (LANE_PERIOD[n*PERIOD_W +: PERIOD_W]),
            .STEP    (LANE_STEP[n*STEP_W +: STEP_W]),
            .INIT_X  (LANE_INIT_X[n*X_W +: X_W])
        ) u_lane (
            .clk     (i_Clk),
            .rst_n   (i_Rst_N),
            .tick    (tick_cond),
            .pause   (i_Pause),
            .restart (i_Restart),
            .level   (i_Level),
            .x       (lane_x[n])
        );
    end

    assign o_Car_1X_Position = lane_x[0];
    assign o_Car_2X_Position = lane_x[1];
    assign o_Car_3X_Position = lane_x[2];
    assign o_Car_4X_Position = lane_x[3];
    assign o_Reverse         = LANE_REVERSE;
    assign o_Frame_Tick      = frame_tick_q;

endmodule

// File: tb/tb_car_lane_controller.sv
// Bench for car_lane_controller. Stimulus drives sync counters directly with
// short synthetic frames (near-miss coordinates, then the blanking start).
// Each issued tick pushes the expected positions into a queue; a monitor on
// the falling edge pops and compares whenever o_Frame_Tick is high, and
// otherwise requires the positions to be unchanged.
module tb_car_lane_controller;

    logic       i_Clk = 1'b0;
    logic       i_Rst_N;
    logic [9:0] i_H_Counter;
    logic [9:0] i_V_Counter;
    logic       i_Pause;
    logic       i_Restart;
    logic [1:0] i_Level;
    logic [9:0] o_Car_1X_Position;
    logic [9:0] o_Car_2X_Position;
    logic [9:0] o_Car_3X_Position;
    logic [9:0] o_Car_4X_Position;
    logic [3:0] o_Reverse;
    logic       o_Frame_Tick;

    car_lane_controller dut (
        .i_Clk             (i_Clk),
        .i_Rst_N           (i_Rst_N),
        .i_H_Counter       (i_H_Counter),
        .i_V_Counter       (i_V_Counter),
        .i_Pause           (i_Pause),
        .i_Restart         (i_Restart),
        .i_Level           (i_Level),
        .o_Car_1X_Position (o_Car_1X_Position),
        .o_Car_2X_Position (o_Car_2X_Position),
        .o_Car_3X_Position (o_Car_3X_Position),
        .o_Car_4X_Position (o_Car_4X_Position),
        .o_Reverse         (o_Reverse),
        .o_Frame_Tick      (o_Frame_Tick)
    );

    always #5 i_Clk = ~i_Clk;

    int n_checks = 0;
    int n_pass   = 0;
    int ticks_issued = 0;
    int ticks_seen   = 0;

    // Lane constants, lane 1 first
    int per [4] = '{1, 2, 3, 4};
    int stp [4] = '{2, 3, 2, 4};
    int ini [4] = '{0, 160, 320, 480};
    int rev [4] = '{0, 1, 0, 1};
    int mx  [4];
    int md  [4];

    logic [39:0] exp_q [$];

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, expv);
    endtask

    task automatic chk_pos(input string name, input int a, input int b, input int c, input int d);
        chk({name, " lane1"}, int'(o_Car_1X_Position), a);
        chk({name, " lane2"}, int'(o_Car_2X_Position), b);
        chk({name, " lane3"}, int'(o_Car_3X_Position), c);
        chk({name, " lane4"}, int'(o_Car_4X_Position), d);
    endtask

    function automatic int eff(input int p, input int lvl);
        int e;
        e = p / (1 << lvl);
        return (e < 1) ? 1 : e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mx[i] = ini[i];
            md[i] = 0;
        end
    endtask

    task automatic model_tick();
        if (i_Pause) return;
        for (int i = 0; i < 4; i++) begin
            md[i] = md[i] + 1;
            if (md[i] >= eff(per[i], int'(i_Level))) begin
                md[i] = 0;
                if (rev[i] != 0) mx[i] = (mx[i] < stp[i]) ? 608 : mx[i] - stp[i];
                else             mx[i] = (mx[i] + stp[i] > 608) ? 0 : mx[i] + stp[i];
            end
        end
    endtask

    task automatic drive(input int h, input int v);
        @(posedge i_Clk);
        #1;
        i_H_Counter = 10'(h);
        i_V_Counter = 10'(v);
        i_Restart   = 1'b0;
    endtask

    task automatic frame(input bit restart_at_tick);
        drive(0, 0);
        drive(639, 479);
        drive(0, 479);
        drive(1, 480);
        drive(0, 481);
        drive(700, 480);
        @(posedge i_Clk);
        #1;
        i_H_Counter = 10'd0;
        i_V_Counter = 10'd480;
        i_Restart   = restart_at_tick;
        if (restart_at_tick) model_reset();
        else                 model_tick();
        exp_q.push_back({10'(mx[3]), 10'(mx[2]), 10'(mx[1]), 10'(mx[0])});
        ticks_issued++;
        drive(1, 480);
        drive(2, 480);
    endtask

    task automatic pulse_restart();
        @(posedge i_Clk);
        #1;
        i_Restart = 1'b1;
        model_reset();
        drive(3, 480);
    endtask

    // Monitor / scoreboard
    logic [39:0] prev_pos;
    logic [39:0] cur_pos;
    logic [39:0] e;
    bit          skip_stable = 1'b1;

    always @(negedge i_Clk) begin
        cur_pos = {o_Car_4X_Position, o_Car_3X_Position, o_Car_2X_Position, o_Car_1X_Position};
        if (i_Rst_N !== 1'b1) begin
            skip_stable = 1'b1;
        end else if (o_Frame_Tick) begin
            ticks_seen++;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_tick: got pulse expected none (pos %h)", cur_pos);
            end else begin
                e = exp_q.pop_front();
                chk("tick lane1", int'(o_Car_1X_Position), int'(e[9:0]));
                chk("tick lane2", int'(o_Car_2X_Position), int'(e[19:10]));
                chk("tick lane3", int'(o_Car_3X_Position), int'(e[29:20]));
                chk("tick lane4", int'(o_Car_4X_Position), int'(e[39:30]));
            end
        end else if (!skip_stable) begin
            n_checks++;
            if (cur_pos == prev_pos) n_pass++;
            else $display("FAIL stable: got %h expected %h at H=%0d V=%0d",
                          cur_pos, prev_pos, i_H_Counter, i_V_Counter);
        end
        prev_pos    = cur_pos;
        skip_stable = (i_Rst_N !== 1'b1) || i_Restart;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_Rst_N     = 1'b0;
        i_H_Counter = 10'd0;
        i_V_Counter = 10'd0;
        i_Pause     = 1'b0;
        i_Restart   = 1'b0;
        i_Level     = 2'd0;
        model_reset();
        repeat (3) @(posedge i_Clk);
        #1;
        chk_pos("reset", 0, 160, 320, 480);
        chk("reset reverse", int'(o_Reverse), 4'b1010);
        chk("reset tick", int'(o_Frame_Tick), 0);
        @(posedge i_Clk);
        #3;
        i_Rst_N = 1'b1;

        // Level 0 divider sequence
        repeat (4) frame(1'b0);
        drive(10, 10);
        chk_pos("level0 4 frames", 8, 154, 322, 476);

        // Reset in the middle of the visible area
        drive(320, 200);
        #2;
        i_Rst_N = 1'b0;
        #1;
        chk_pos("midframe reset", 0, 160, 320, 480);
        chk("midframe reset tick", int'(o_Frame_Tick), 0);
        chk("midframe reverse", int'(o_Reverse), 4'b1010);
        model_reset();
        repeat (2) @(posedge i_Clk);
        #3;
        i_Rst_N = 1'b1;
        frame(1'b0);
        drive(10, 10);
        chk_pos("first frame after reset", 2, 160, 320, 480);
        repeat (3) frame(1'b0);

        // Pause holds positions and dividers; ticks keep pulsing
        i_Pause = 1'b1;
        repeat (5) frame(1'b0);
        drive(10, 10);
        chk_pos("paused", 8, 154, 322, 476);
        i_Pause = 1'b0;
        repeat (2) frame(1'b0);
        drive(10, 10);
        chk_pos("resume", 12, 151, 324, 476);

        // Restart coincident with a tick, while paused as well
        i_Pause = 1'b1;
        frame(1'b1);
        i_Pause = 1'b0;
        drive(10, 10);
        chk_pos("restart at tick", 0, 160, 320, 480);

        // Level change mid-count
        i_Level = 2'd1;
        frame(1'b0);
        i_Level = 2'd0;
        frame(1'b0);
        i_Level = 2'd1;
        frame(1'b0);
        drive(10, 10);
        chk_pos("level change", 6, 154, 324, 476);

        // Level 2: every lane at one frame per step
        pulse_restart();
        i_Level = 2'd2;
        frame(1'b0);
        drive(10, 10);
        chk_pos("level2", 2, 157, 322, 476);

        // Level 3 long run through both wrap directions
        pulse_restart();
        i_Level = 2'd3;
        repeat (310) frame(1'b0);
        drive(10, 10);
        chk_pos("level3 wraps", 10, 449, 330, 464);

        repeat (4) drive(20, 20);
        chk("ticks seen", ticks_seen, ticks_issued);
        chk("queue drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
